// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encode definitions: opcodes, funct fields, op enum, loader FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package instr_encoder_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  typedef enum logic [1:0] {
    ENC_ADD  = 2'b00,
    ENC_SUB  = 2'b01,
    ENC_ADDI = 2'b10,
    ENC_RSVD = 2'b11
  } enc_op_e;

  typedef enum logic {
    ST_LOADING = 1'b0,
    ST_FULL    = 1'b1
  } ld_state_e;

  // Pure packer; only imm[11:0] reaches the word, range policy lives in the caller.
  function automatic logic [31:0] encode(enc_op_e op, logic [4:0] rd, logic [4:0] rs1,
                                         logic [4:0] rs2, logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    case (op)
      ENC_ADD:  w = {F7_ADD, rs2, rs1, F3_ADD, rd, OPC_OP};
      ENC_SUB:  w = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_OP};
      ENC_ADDI: w = {imm[11:0], rs1, F3_ADD, rd, OPC_OP_IMM};
      default:  w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bus of the instruction encoder (symbolic op in, addr/word out).
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the output stream.
//   master: request producer + output sink (testbench / loader front end)
//   slave : the encoder
interface instr_encoder_if #(
  parameter int AW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder_fifo.sv
// 2-entry FIFO of {addr, instr}, width W, with occupancy count.
// Latency: push visible at head on the next cycle; no pass-through.
// Backpressure: caller must not push when count==2 nor pop when count==0.
//   ports: clk, rst (async high), flush (sync clear), push/wdat, pop/rdat, count
module enc_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] rdat,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdat  = mem[rd_ptr];
  assign count = cnt_q;
endmodule

// File: rtl/instr_encoder.sv
// Encodes ADD/SUB/ADDI requests into RV32I words and emits (byte addr, word) for imem loading.
// Latency: 1 cycle from accept to out_valid when empty; 1 word/cycle sustained.
// Backpressure: in_ready = !full && fifo not full (registered state only); outputs hold until out_ready.
//   ports: clk, rst (async high), flush (sync clear), bus (instr_encoder_if.slave),
//          full (MEM_WORDS enqueued), err (1-cycle pulse on a dropped request)
//   optional: IMM_RANGE_CHECK_EN -- ADDI immediates outside [-2048, 2047] are dropped as errors
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            MEM_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  instr_encoder_if.slave   bus,
  output logic             full,
  output logic             err
);
  localparam int IW = $clog2(MEM_WORDS + 1);

  ld_state_e     state_q, state_d;
  logic [IW-1:0] idx_q;
  logic          err_q;
  logic [1:0]    fifo_cnt;
  logic [AW+31:0] fifo_rdat;

  enc_op_e       op;
  logic          accept;
  logic          bad_req;
  logic          push;
  logic          pop;
  logic          last_word;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_instr;

  assign op = enc_op_e'(bus.in_op);

`ifdef IMM_RANGE_CHECK_EN
  // In range iff bits [31:11] are a pure sign extension.
  logic imm_fits;
  assign imm_fits = (&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]);
  assign bad_req  = (op == ENC_RSVD) || ((op == ENC_ADDI) && !imm_fits);
`else
  assign bad_req  = (op == ENC_RSVD);
`endif

  // flush discards any same-cycle handshake on either side.
  assign bus.in_ready = (state_q == ST_LOADING) && (fifo_cnt < 2'd2);
  assign accept       = bus.in_valid && bus.in_ready && !flush;
  assign push         = accept && !bad_req;
  assign pop          = bus.out_valid && bus.out_ready && !flush;
  assign last_word    = (idx_q == IW'(MEM_WORDS - 1));

  assign wr_addr  = BASE_ADDR + (AW'(idx_q) << 2);
  assign wr_instr = encode(op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);

  enc_fifo #(.W(AW + 32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdat  ({wr_addr, wr_instr}),
    .pop   (pop),
    .rdat  (fifo_rdat),
    .count (fifo_cnt)
  );

  assign bus.out_valid = (fifo_cnt != 2'd0);
  assign bus.out_addr  = fifo_rdat[AW+31:32];
  assign bus.out_instr = fifo_rdat[31:0];

  // Loader FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_LOADING;
    else     state_q <= state_d;
  end

  // Loader FSM: next state.
  always_comb begin
    state_d = state_q;
    if (flush)                                    state_d = ST_LOADING;
    else if (state_q == ST_LOADING && push && last_word) state_d = ST_FULL;
  end

  // Loader FSM: outputs.
  always_comb begin
    full = (state_q == ST_FULL);
  end

  // Word index counts enqueued words only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      err_q <= 1'b0;
    end else if (flush) begin
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (push) idx_q <= idx_q + 1'b1;
      err_q <= accept && bad_req;
    end
  end

  assign err = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (MEM_WORDS=4, nonzero base address).
// Latency: n/a.
// Backpressure: bench drives out_ready directly.
module tb_instr_encoder;
  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic full, err;
  int   total = 0;
  int   bad = 0;

  instr_encoder_if #(.AW(AW)) bus ();

  instr_encoder #(.AW(AW), .BASE_ADDR(BASE), .MEM_WORDS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .full  (full),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
  endtask

  task automatic do_flush();
    bus.in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL rst_out_instr got=%h want=0", bus.out_instr); end
    total++; if (bus.out_addr !== 32'h0) begin bad++; $display("FAIL rst_out_addr got=%h want=0", bus.out_addr); end
    total++; if (full !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_full_err got=%0b%0b want=00", full, err); end
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", bus.in_ready); end
  endtask

  task automatic test_add();
    do_flush();
    bus.out_ready = 1'b1;
    drive(2'b00, 5'd1, 5'd2, 5'd3, 32'h0);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_instr !== 32'h003100B3) begin bad++; $display("FAIL add_instr got=%h want=003100b3", bus.out_instr); end
    total++; if (bus.out_addr !== BASE) begin bad++; $display("FAIL add_addr got=%h want=%h", bus.out_addr, BASE); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%0b want=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    do_flush();
    bus.out_ready = 1'b1;
    drive(2'b01, 5'd5, 5'd6, 5'd7, 32'h0);
    step();
    drive(2'b10, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    total++; if (bus.out_instr !== 32'h407302B3 || bus.out_addr !== BASE) begin bad++; $display("FAIL b2b_sub got=%h@%h want=407302b3@%h", bus.out_instr, bus.out_addr, BASE); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b want=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF00093 || bus.out_addr !== BASE + 32'd4) begin bad++; $display("FAIL b2b_addi got=%0b %h@%h want=1 fff00093@%h", bus.out_valid, bus.out_instr, bus.out_addr, BASE + 32'd4); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0b want=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    do_flush();
    bus.out_ready = 1'b0;
    drive(2'b00, 5'd1, 5'd0, 5'd0, 32'h0);
    step();
    drive(2'b00, 5'd2, 5'd0, 5'd0, 32'h0);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%0b want=1", bus.in_ready); end
    step();
    drive(2'b00, 5'd3, 5'd0, 5'd0, 32'h0);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready2 got=%0b want=0", bus.in_ready); end
    step();
    step();
    total++; if (bus.in_ready !== 1'b0 || bus.out_instr !== 32'h000000B3 || bus.out_addr !== BASE) begin bad++; $display("FAIL bp_hold got=%0b %h@%h want=0 000000b3@%h", bus.in_ready, bus.out_instr, bus.out_addr, BASE); end
    bus.out_ready = 1'b1;
    step();
    total++; if (bus.out_instr !== 32'h00000133 || bus.out_addr !== BASE + 32'd4) begin bad++; $display("FAIL bp_w1 got=%h@%h want=00000133@%h", bus.out_instr, bus.out_addr, BASE + 32'd4); end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h000001B3 || bus.out_addr !== BASE + 32'd8) begin bad++; $display("FAIL bp_w2 got=%0b %h@%h want=1 000001b3@%h", bus.out_valid, bus.out_instr, bus.out_addr, BASE + 32'd8); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b want=0", bus.out_valid); end
  endtask

  task automatic test_full();
    do_flush();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 5'(i + 1), 5'd0, 5'd0, 32'h0);
      total++; if (bus.in_ready !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL full_pre%0d got=rdy%0b full%0b want=rdy1 full0", i, bus.in_ready, full); end
      step();
      total++; if (bus.out_addr !== BASE + 32'(4 * i)) begin bad++; $display("FAIL full_addr%0d got=%h want=%h", i, bus.out_addr, BASE + 32'(4 * i)); end
    end
    drive(2'b00, 5'd9, 5'd0, 5'd0, 32'h0);
    total++; if (full !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_set got=full%0b rdy%0b want=full1 rdy0", full, bus.in_ready); end
    step();
    total++; if (bus.out_valid !== 1'b0 || full !== 1'b1) begin bad++; $display("FAIL full_5th got=vld%0b full%0b want=vld0 full1", bus.out_valid, full); end
    do_flush();
    total++; if (full !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_flush got=full%0b rdy%0b want=full0 rdy1", full, bus.in_ready); end
    drive(2'b00, 5'd9, 5'd0, 5'd0, 32'h0);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_addr !== BASE) begin bad++; $display("FAIL full_after got=%0b@%h want=1@%h", bus.out_valid, bus.out_addr, BASE); end
    step();
  endtask

  task automatic test_err();
    do_flush();
    bus.out_ready = 1'b1;
    drive(2'b11, 5'd1, 5'd1, 5'd1, 32'h0);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL err_ready got=%0b want=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    total++; if (err !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL err_pulse got=err%0b vld%0b want=err1 vld0", err, bus.out_valid); end
    step();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b want=0", err); end
    drive(2'b00, 5'd4, 5'd0, 5'd0, 32'h0);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_addr !== BASE) begin bad++; $display("FAIL err_addr got=%0b@%h want=1@%h", bus.out_valid, bus.out_addr, BASE); end
    step();
    // Lower boundary is in range in every build.
    drive(2'b10, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h80000013 || bus.out_addr !== BASE + 32'd4 || err !== 1'b0) begin bad++; $display("FAIL imm_min got=%0b %h@%h err%0b want=1 80000013@%h err0", bus.out_valid, bus.out_instr, bus.out_addr, err, BASE + 32'd4); end
    step();
    drive(2'b10, 5'd0, 5'd0, 5'd0, 32'd2048);
    step();
    bus.in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    total++; if (err !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL imm_2048 got=err%0b vld%0b want=err1 vld0", err, bus.out_valid); end
`else
    total++; if (err !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_instr !== 32'h80000013 || bus.out_addr !== BASE + 32'd8) begin bad++; $display("FAIL imm_2048 got=err%0b %0b %h@%h want=err0 1 80000013@%h", err, bus.out_valid, bus.out_instr, bus.out_addr, BASE + 32'd8); end
`endif
    step();
  endtask

  task automatic test_async_rst_flush();
    do_flush();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 5'(i + 1), 5'd0, 5'd0, 32'h0);
      step();
    end
    bus.out_ready = 1'b0;
    drive(2'b00, 5'd4, 5'd0, 5'd0, 32'h0);
    step();
    bus.in_valid = 1'b0;
    total++; if (full !== 1'b1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL arst_pre got=full%0b vld%0b rdy%0b want=1 1 0", full, bus.out_valid, bus.in_ready); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || full !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL arst_now got=vld%0b full%0b rdy%0b want=0 0 1", bus.out_valid, full, bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    step();
    bus.out_ready = 1'b1;
    drive(2'b00, 5'd7, 5'd0, 5'd0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL flush_push got=vld%0b err%0b want=0 0", bus.out_valid, err); end
    drive(2'b00, 5'd8, 5'd0, 5'd0, 32'h0);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00000433 || bus.out_addr !== BASE) begin bad++; $display("FAIL flush_next got=%0b %h@%h want=1 00000433@%h", bus.out_valid, bus.out_instr, bus.out_addr, BASE); end
    step();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_full();
    test_err();
    test_async_rst_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
